// File: rtl/local_ni.sv
// Local network interface between a processing core and router port 4.
// Queues and replays core flits toward the router, buffers ejected flits for the core.
//
// state | meaning
// IDLE  | router_in = 0, waiting for a queued flit
// SEND  | router_in carries the head flit (one cycle)
// WAIT  | router_in = 0, inj_grant sampled at the closing edge
module local_ni #(
  parameter int DATA_WIDTH = 32,
  parameter int VLD_POS    = DATA_WIDTH - 1,
  parameter int INJ_DEPTH  = 4,
  parameter int EJ_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  inj_valid,
  output logic                  inj_ready,
  input  logic [DATA_WIDTH-1:0] inj_flit,
  output logic [DATA_WIDTH-1:0] router_in,
  input  logic                  inj_grant,
  input  logic [DATA_WIDTH-1:0] router_out,
  output logic                  ej_valid,
  input  logic                  ej_ready,
  output logic [DATA_WIDTH-1:0] ej_flit,
  output logic                  ej_overflow,
  output logic [15:0]           inj_retry_cnt
);

  localparam int IAW = $clog2(INJ_DEPTH);
  localparam int EAW = $clog2(EJ_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  // ---------------- injection FIFO ----------------
  logic [DATA_WIDTH-1:0] inj_mem [INJ_DEPTH];
  logic [IAW:0]          inj_wr, inj_rd, inj_count;
  logic [IAW-1:0]        inj_rd_next;
  logic                  inj_empty, inj_full, inj_push, inj_pop;
  logic [DATA_WIDTH-1:0] inj_head, inj_head_next;

  assign inj_count     = inj_wr - inj_rd;
  assign inj_empty     = (inj_wr == inj_rd);
  assign inj_full      = (inj_wr[IAW] != inj_rd[IAW]) && (inj_wr[IAW-1:0] == inj_rd[IAW-1:0]);
  assign inj_ready     = !inj_full;
  assign inj_push      = inj_valid && inj_ready;
  assign inj_rd_next   = inj_rd[IAW-1:0] + IAW'(1);
  assign inj_head      = inj_mem[inj_rd[IAW-1:0]];
  assign inj_head_next = inj_mem[inj_rd_next];

  always_ff @(posedge clk) begin
    if (inj_push) inj_mem[inj_wr[IAW-1:0]] <= inj_flit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inj_wr <= '0;
      inj_rd <= '0;
    end else begin
      if (inj_push) inj_wr <= inj_wr + (IAW+1)'(1);
      if (inj_pop)  inj_rd <= inj_rd + (IAW+1)'(1);
    end
  end

  // ---------------- injection FSM ----------------
  state_t                state_q, state_d;
  logic                  load, retry_inc;
  logic [DATA_WIDTH-1:0] load_flit, router_in_d;

  always_comb begin
    state_d   = state_q;
    inj_pop   = 1'b0;
    load      = 1'b0;
    retry_inc = 1'b0;
    load_flit = inj_head;
    case (state_q)
      IDLE: begin
        if (!inj_empty) begin
          state_d = SEND;
          load    = 1'b1;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (inj_grant) begin
          inj_pop = 1'b1;
          // the head is leaving, so the replacement comes from the next slot
          if (inj_count > (IAW+1)'(1)) begin
            state_d   = SEND;
            load      = 1'b1;
            load_flit = inj_head_next;
          end else begin
            state_d = IDLE;
          end
        end else begin
          retry_inc = 1'b1;
          state_d   = SEND;
          load      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    router_in_d = '0;
    if (load) begin
      router_in_d          = load_flit;
      router_in_d[VLD_POS] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      router_in     <= '0;
      inj_retry_cnt <= '0;
    end else begin
      state_q   <= state_d;
      router_in <= router_in_d;
      if (retry_inc && (inj_retry_cnt != 16'hFFFF))
        inj_retry_cnt <= inj_retry_cnt + 16'd1;
    end
  end

  // ---------------- ejection FIFO ----------------
  logic [DATA_WIDTH-1:0] ej_mem [EJ_DEPTH];
  logic [EAW:0]          ej_wr, ej_rd;
  logic                  ej_empty, ej_full, ej_push, ej_pop, ej_write, ej_drop;

  assign ej_empty = (ej_wr == ej_rd);
  assign ej_full  = (ej_wr[EAW] != ej_rd[EAW]) && (ej_wr[EAW-1:0] == ej_rd[EAW-1:0]);
  assign ej_valid = !ej_empty;
  assign ej_flit  = ej_empty ? '0 : ej_mem[ej_rd[EAW-1:0]];
  assign ej_push  = router_out[VLD_POS];
  assign ej_pop   = ej_valid && ej_ready;
  // a simultaneous pop frees the slot the incoming flit needs
  assign ej_write = ej_push && (!ej_full || ej_pop);
  assign ej_drop  = ej_push && ej_full && !ej_pop;

  always_ff @(posedge clk) begin
    if (ej_write) ej_mem[ej_wr[EAW-1:0]] <= router_out;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ej_wr       <= '0;
      ej_rd       <= '0;
      ej_overflow <= 1'b0;
    end else begin
      if (ej_write) ej_wr <= ej_wr + (EAW+1)'(1);
      if (ej_pop)   ej_rd <= ej_rd + (EAW+1)'(1);
      if (ej_drop)  ej_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_ni.sv
// Directed bench for local_ni: cycle vector table plus hand-written
// sequences for FIFO-full, ejection overflow and mid-traffic reset.
module tb_local_ni;

  localparam logic [31:0] VLD = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        inj_valid = 1'b0;
  logic        inj_ready;
  logic [31:0] inj_flit = '0;
  logic [31:0] router_in;
  logic        inj_grant = 1'b0;
  logic [31:0] router_out = '0;
  logic        ej_valid;
  logic        ej_ready = 1'b0;
  logic [31:0] ej_flit;
  logic        ej_overflow;
  logic [15:0] inj_retry_cnt;

  int checks = 0;
  int errors = 0;

  local_ni dut (
    .clk(clk), .n_rst(n_rst),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_flit(inj_flit),
    .router_in(router_in), .inj_grant(inj_grant), .router_out(router_out),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_flit(ej_flit),
    .ej_overflow(ej_overflow), .inj_retry_cnt(inj_retry_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ifl;
    logic        g;
    logic [31:0] ro;
    logic        er;
    logic [31:0] e_ri;
    logic        e_irdy;
    logic        e_ev;
    logic [31:0] e_ef;
    logic        e_ov;
    logic [15:0] e_rc;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] sent[$];

  task automatic add(input logic iv, input logic [31:0] ifl, input logic g,
                     input logic [31:0] ro, input logic er, input logic [31:0] e_ri,
                     input logic e_irdy, input logic e_ev, input logic [31:0] e_ef,
                     input logic e_ov, input logic [15:0] e_rc);
    vec_t v;
    v.iv = iv; v.ifl = ifl; v.g = g; v.ro = ro; v.er = er;
    v.e_ri = e_ri; v.e_irdy = e_irdy; v.e_ev = e_ev; v.e_ef = e_ef;
    v.e_ov = e_ov; v.e_rc = e_rc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] f [5];
    bit          first_pop;
    bit          stale;

    // ---------- vector table ----------
    //  iv    flit          g     router_out    er  |  router_in       rdy   ev    ej_flit       ov    retry
    // single inject, granted (grant in IDLE/SEND is ignored)
    add(1'b1, 32'h1234_56A5, 1'b1, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h9234_56A5, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    // refusal and replay: A refused three times, then A and B granted
    add(1'b1, 32'h0000_00A5, 1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b1, 32'h0000_00B6, 1'b0, 32'h0,       1'b0, 32'h8000_00A5, 1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd0);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h8000_00A5, 1'b1, 1'b0, 32'h0,        1'b0, 16'd1);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd1);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h8000_00A5, 1'b1, 1'b0, 32'h0,        1'b0, 16'd2);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd2);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h8000_00A5, 1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h8000_00B6, 1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b0, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b1, 32'h0,       1'b0, 32'h0,         1'b1, 1'b0, 32'h0,        1'b0, 16'd3);
    // ejection basics: capture, pop+push same cycle, VLD=0 ignored
    add(1'b0, 32'h0,         1'b0, 32'h8000_0011, 1'b0, 32'h0,       1'b1, 1'b1, 32'h8000_0011, 1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b0, 32'h8000_0022, 1'b1, 32'h0,       1'b1, 1'b1, 32'h8000_0022, 1'b0, 16'd3);
    add(1'b0, 32'h0,         1'b0, 32'h0000_0033, 1'b1, 32'h0,       1'b1, 1'b0, 32'h0,        1'b0, 16'd3);

    // ---------- reset then idle ----------
    #22;
    chk("rst router_in", router_in, 32'h0);
    chk("rst inj_ready", 32'(inj_ready), 32'h1);
    chk("rst ej_valid", 32'(ej_valid), 32'h0);
    chk("rst ej_flit", ej_flit, 32'h0);
    chk("rst ej_overflow", 32'(ej_overflow), 32'h0);
    chk("rst retry", 32'(inj_retry_cnt), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle router_in", router_in, 32'h0);
      chk("idle inj_ready", 32'(inj_ready), 32'h1);
    end

    // ---------- table ----------
    for (int i = 0; i < vecs.size(); i++) begin
      inj_valid  = vecs[i].iv;
      inj_flit   = vecs[i].ifl;
      inj_grant  = vecs[i].g;
      router_out = vecs[i].ro;
      ej_ready   = vecs[i].er;
      step();
      chk($sformatf("row%0d router_in", i), router_in, vecs[i].e_ri);
      chk($sformatf("row%0d inj_ready", i), 32'(inj_ready), 32'(vecs[i].e_irdy));
      chk($sformatf("row%0d ej_valid", i), 32'(ej_valid), 32'(vecs[i].e_ev));
      chk($sformatf("row%0d ej_flit", i), ej_flit, vecs[i].e_ef);
      chk($sformatf("row%0d ej_overflow", i), 32'(ej_overflow), 32'(vecs[i].e_ov));
      chk($sformatf("row%0d retry", i), 32'(inj_retry_cnt), 32'(vecs[i].e_rc));
    end
    inj_valid = 1'b0; inj_grant = 1'b0; router_out = '0; ej_ready = 1'b0;

    // ---------- injection full ----------
    for (int i = 0; i < 5; i++) f[i] = 32'h0000_0C00 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1;
      inj_flit  = f[i];
      step();
    end
    chk("full inj_ready", 32'(inj_ready), 32'h0);
    inj_flit = f[4];
    for (int i = 0; i < 6; i++) begin
      step();
      chk("full held inj_ready", 32'(inj_ready), 32'h0);
    end
    inj_valid = 1'b0;
    chk("full router_in before drain", router_in, f[0] | VLD);
    first_pop = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (router_in != 32'h0) begin
        sent.push_back(router_in);
        step();
        inj_grant = 1'b1;
        step();
        inj_grant = 1'b0;
        if (first_pop) begin
          chk("inj_ready after first pop", 32'(inj_ready), 32'h1);
          first_pop = 1'b0;
        end
      end else begin
        step();
      end
    end
    chk("full sent count", 32'(sent.size()), 32'd4);
    for (int i = 0; i < 4 && i < sent.size(); i++)
      chk($sformatf("full order %0d", i), sent[i], f[i] | VLD);
    chk("full retry", 32'(inj_retry_cnt), 32'd7);
    chk("full router_in idle", router_in, 32'h0);

    // ---------- ejection overflow ----------
    ej_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      router_out = VLD | (32'h100 + 32'(i));
      step();
      if (i == 7) chk("ej ovf before drop", 32'(ej_overflow), 32'h0);
      chk("ej head stable", ej_flit, VLD | 32'h100);
    end
    router_out = '0;
    chk("ej ovf after drop", 32'(ej_overflow), 32'h1);
    ej_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ej drain1 valid %0d", i), 32'(ej_valid), 32'h1);
      chk($sformatf("ej drain1 flit %0d", i), ej_flit, VLD | (32'h100 + 32'(i)));
      step();
    end
    chk("ej drain1 empty", 32'(ej_valid), 32'h0);
    ej_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      router_out = VLD | (32'h200 + 32'(i));
      step();
    end
    router_out = VLD | 32'h208;
    ej_ready   = 1'b1;
    step();
    router_out = '0;
    ej_ready   = 1'b0;
    chk("ej full pop+push head", ej_flit, VLD | 32'h201);
    ej_ready = 1'b1;
    for (int i = 1; i < 9; i++) begin
      chk($sformatf("ej drain2 valid %0d", i), 32'(ej_valid), 32'h1);
      chk($sformatf("ej drain2 flit %0d", i), ej_flit, VLD | (32'h200 + 32'(i)));
      step();
    end
    chk("ej drain2 empty", 32'(ej_valid), 32'h0);
    chk("ej ovf sticky", 32'(ej_overflow), 32'h1);
    ej_ready = 1'b0;

    // ---------- reset mid-traffic ----------
    inj_valid = 1'b1; inj_flit = 32'h0000_0D01; router_out = VLD | 32'h301;
    step();
    inj_flit = 32'h0000_0D02; router_out = VLD | 32'h302;
    step();
    inj_valid = 1'b0; router_out = '0;
    chk("mid SEND router_in", router_in, VLD | 32'h0D01);
    chk("mid ej_valid", 32'(ej_valid), 32'h1);
    #2 n_rst = 1'b0;
    #1;
    chk("mid rst router_in", router_in, 32'h0);
    chk("mid rst ej_valid", 32'(ej_valid), 32'h0);
    chk("mid rst ej_flit", ej_flit, 32'h0);
    chk("mid rst inj_ready", 32'(inj_ready), 32'h1);
    chk("mid rst ej_overflow", 32'(ej_overflow), 32'h0);
    chk("mid rst retry", 32'(inj_retry_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    inj_grant = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (router_in != 32'h0 || ej_valid) stale = 1'b1;
    end
    inj_grant = 1'b0;
    chk("no stale after reset", 32'(stale), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
